// File: rtl/cpu_run_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl_pkg
// Shared definitions for the CPU run controller: state encoding (also used by
// the debug display via o_state), load defaults, and a small decode helper.
// ----------------------------------------------------------------------------
package cpu_run_ctrl_pkg;

   // FSM state encoding (3 bits, values fixed for the debug display)
   localparam logic [2:0] ST_LOAD      = 3'd0;
   localparam logic [2:0] ST_READY     = 3'd1;
   localparam logic [2:0] ST_RUN       = 3'd2;
   localparam logic [2:0] ST_STEP_IDLE = 3'd3;
   localparam logic [2:0] ST_STEP_EXEC = 3'd4;
   localparam logic [2:0] ST_HALTED    = 3'd5;

   // Load defaults
   localparam logic [15:0] HALT_WORD_DEF  = 16'hE000;
   localparam int          START_ADDR_DEF = 1;

   // The CPU may fetch/execute only while free-running or inside a step window
   function automatic logic cpu_go_state(input logic [2:0] st);
      return (st == ST_RUN) || (st == ST_STEP_EXEC);
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl_if
// Byte-in / instruction-memory-write bus of the run controller.
//   i_rx_valid / i_rx_data              : UART receiver byte strobe + data
//   o_imem_we / o_imem_addr / o_imem_wdata : instruction memory write port
// master = controller side, slave = environment (UART + memory) side.
// ----------------------------------------------------------------------------
interface cpu_run_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              i_rx_valid;
   logic [7:0]        i_rx_data;
   logic              o_imem_we;
   logic [ADDR_W-1:0] o_imem_addr;
   logic [15:0]       o_imem_wdata;

   modport master (
      input  i_rx_valid, i_rx_data,
      output o_imem_we, o_imem_addr, o_imem_wdata
   );

   modport slave (
      output i_rx_valid, i_rx_data,
      input  o_imem_we, o_imem_addr, o_imem_wdata
   );
endinterface

// File: rtl/cpu_run_ctrl_edge_detect_rise.sv
// ----------------------------------------------------------------------------
// edge_detect_rise
// Rising-edge detector: compares the input with its registered previous
// sample. The sample register resets to 0.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_sig          : level or pulse input
//   o_rise         : high for the cycle in which i_sig is 1 and was 0 before
// ----------------------------------------------------------------------------
module edge_detect_rise (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   output logic o_rise
);
   logic prev_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) prev_q <= 1'b0;
      else          prev_q <= i_sig;
   end

   assign o_rise = i_sig & ~prev_q;
endmodule

// File: rtl/cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl
// Sequencing controller between UART byte receiver, instruction memory and
// CPU control unit.
//   Load phase: byte pairs -> 16-bit words written from START_ADDR upward;
//     ends on HALT_WORD, on IDLE_TIMEOUT idle cycles (after >=1 byte), or on
//     writing the last address.
//   Run phase: gates the CPU with o_cpu_go, continuous or single-step.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   bus (master)            rx byte in, imem write out
//   i_start_cpu             run permitted (level)
//   i_step_mode             1 = step, 0 = continuous
//   i_next_instr            step request (rising edge used)
//   i_instr_done            instruction retired strobe
//   i_halt                  CPU halted (level)
//   o_instr_transmit_done   load finished (sticky until reset)
//   o_max_addr              last address written
//   o_load_err              odd byte count / overflow at load end
//   o_cpu_go                CPU may execute
//   o_state                 current state (debug)
// ----------------------------------------------------------------------------
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int          ADDR_W       = 8,
   parameter int          START_ADDR   = START_ADDR_DEF,
   parameter logic [15:0] HALT_WORD    = HALT_WORD_DEF,
   parameter int          IDLE_TIMEOUT = 50000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   cpu_run_ctrl_if.master    bus,
   input  logic              i_start_cpu,
   input  logic              i_step_mode,
   input  logic              i_next_instr,
   input  logic              i_instr_done,
   input  logic              i_halt,
   output logic              o_instr_transmit_done,
   output logic [ADDR_W-1:0] o_max_addr,
   output logic              o_load_err,
   output logic              o_cpu_go,
   output logic [2:0]        o_state
);
   localparam int                CNT_W      = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(IDLE_TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};

   logic [2:0]        state_q,     state_d;
   logic              toggle_q,    toggle_d;
   logic [7:0]        hi_q,        hi_d;
   logic              seen_q,      seen_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic              we_q,        we_d;
   logic [ADDR_W-1:0] waddr_q,     waddr_d;
   logic [15:0]       wdata_q,     wdata_d;
   logic [ADDR_W-1:0] max_addr_q,  max_addr_d;
   logic              done_q,      done_d;
   logic              err_q,       err_d;

   logic              next_rise;
   logic [15:0]       word;
   logic              timeout;

   edge_detect_rise u_next_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sig   (i_next_instr),
      .o_rise  (next_rise)
   );

   assign word = {hi_q, bus.i_rx_data};

   // Idle limit reached on this edge: counter already at its last value and
   // still no byte arriving, with at least one byte seen since reset.
   assign timeout = seen_q & ~bus.i_rx_valid & (cnt_q == CNT_LAST);

   always_comb begin
      state_d    = state_q;
      toggle_d   = toggle_q;
      hi_d       = hi_q;
      seen_d     = seen_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      max_addr_d = max_addr_q;
      done_d     = done_q;
      err_d      = err_q;

      case (state_q)
         ST_LOAD: begin
            if (bus.i_rx_valid) begin
               cnt_d  = '0;
               seen_d = 1'b1;
            end else if (seen_q) begin
               cnt_d = cnt_q + 1'b1;
            end

            if (bus.i_rx_valid && !toggle_q) begin
               hi_d     = bus.i_rx_data;
               toggle_d = 1'b1;
            end

            // Second byte: the write is presented on the following cycle
            if (bus.i_rx_valid && toggle_q) begin
               toggle_d   = 1'b0;
               we_d       = 1'b1;
               waddr_d    = addr_q;
               wdata_d    = word;
               max_addr_d = addr_q;
               addr_d     = addr_q + 1'b1;
               if (word == HALT_WORD) begin
                  state_d = ST_READY;
                  done_d  = 1'b1;
               end else if (addr_q == ADDR_LAST) begin
                  state_d = ST_READY;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end
            end

            // A dangling high byte at timeout is dropped and flagged
            if (timeout) begin
               state_d  = ST_READY;
               done_d   = 1'b1;
               toggle_d = 1'b0;
               if (toggle_q) err_d = 1'b1;
            end
         end

         ST_READY: begin
            if (i_start_cpu) state_d = i_step_mode ? ST_STEP_IDLE : ST_RUN;
         end

         ST_RUN: begin
            // Switching to step mode waits for the in-flight instruction
            if (i_halt)                         state_d = ST_HALTED;
            else if (!i_start_cpu)              state_d = ST_READY;
            else if (i_step_mode && i_instr_done) state_d = ST_STEP_IDLE;
         end

         ST_STEP_IDLE: begin
            if (i_halt)            state_d = ST_HALTED;
            else if (!i_start_cpu) state_d = ST_READY;
            else if (next_rise)    state_d = ST_STEP_EXEC;
         end

         ST_STEP_EXEC: begin
            // Step requests here are consumed by the edge detector, not queued
            if (i_halt)            state_d = ST_HALTED;
            else if (!i_start_cpu) state_d = ST_READY;
            else if (i_instr_done) state_d = ST_STEP_IDLE;
         end

         ST_HALTED: begin
            state_d = ST_HALTED;
         end

         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_LOAD;
         toggle_q   <= 1'b0;
         hi_q       <= '0;
         seen_q     <= 1'b0;
         cnt_q      <= '0;
         addr_q     <= ADDR_FIRST;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         max_addr_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         toggle_q   <= toggle_d;
         hi_q       <= hi_d;
         seen_q     <= seen_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         max_addr_q <= max_addr_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.o_imem_we          = we_q;
   assign bus.o_imem_addr        = waddr_q;
   assign bus.o_imem_wdata       = wdata_q;
   assign o_instr_transmit_done  = done_q;
   assign o_max_addr             = max_addr_q;
   assign o_load_err             = err_q;
   assign o_cpu_go               = cpu_go_state(state_q);
   assign o_state                = state_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;
   import cpu_run_ctrl_pkg::*;

   localparam int ADDR_W = 8;
   localparam int TMO    = 200;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start, step, nexti, idone, halt;
   logic              done, err, go;
   logic [ADDR_W-1:0] max_addr;
   logic [2:0]        st;

   cpu_run_ctrl_if #(.ADDR_W(ADDR_W)) ifc ();

   cpu_run_ctrl #(.ADDR_W(ADDR_W), .IDLE_TIMEOUT(TMO)) dut (
      .i_clk                 (clk),
      .i_rst_n               (rst_n),
      .bus                   (ifc.master),
      .i_start_cpu           (start),
      .i_step_mode           (step),
      .i_next_instr          (nexti),
      .i_instr_done          (idone),
      .i_halt                (halt),
      .o_instr_transmit_done (done),
      .o_max_addr            (max_addr),
      .o_load_err            (err),
      .o_cpu_go              (go),
      .o_state               (st)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } wr_t;

   typedef logic [7:0] bq_t[$];

   wr_t               exp_q[$];
   bq_t               bq;
   int                errors = 0;
   int                checks = 0;
   logic [ADDR_W-1:0] exp_max;
   logic              exp_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      ifc.i_rx_valid = 1'b1;
      ifc.i_rx_data  = b;
      tick(1);
      ifc.i_rx_valid = 1'b0;
      if (gap > 0) tick(gap);
   endtask

   task automatic add_word(input logic [15:0] w);
      bq.push_back(w[15:8]);
      bq.push_back(w[7:0]);
   endtask

   // Reference: pair bytes into words, stop on the halt word or after the
   // last address; a leftover single byte means the load ends in error.
   task automatic model_load(input bq_t bytes);
      int          a;
      bit          ended;
      logic [15:0] w;
      wr_t         e;
      a       = START_ADDR_DEF;
      ended   = 1'b0;
      exp_max = '0;
      exp_err = 1'b0;
      for (int i = 0; (i + 1 < bytes.size()) && !ended; i += 2) begin
         w      = {bytes[i], bytes[i+1]};
         e.addr = a[ADDR_W-1:0];
         e.data = w;
         exp_q.push_back(e);
         exp_max = a[ADDR_W-1:0];
         if (w == HALT_WORD_DEF) ended = 1'b1;
         else if (a == (2**ADDR_W) - 1) begin
            ended   = 1'b1;
            exp_err = 1'b1;
         end
         a++;
      end
      if (!ended && (bytes.size() % 2 == 1)) exp_err = 1'b1;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick(1);
         n++;
      end
      check("done_wait", 32'(done), 32'd1);
   endtask

   task automatic run_load(input string tag, input int maxgap);
      model_load(bq);
      foreach (bq[i]) send_byte(bq[i], $urandom_range(0, maxgap));
      wait_done(TMO + 50);
      tick(2);
      check({tag, "_max_addr"}, 32'(max_addr), 32'(exp_max));
      check({tag, "_load_err"}, 32'(err), 32'(exp_err));
      check({tag, "_state"}, 32'(st), 32'(ST_READY));
      check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      bq.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0; step = 1'b0; nexti = 1'b0; idone = 1'b0; halt = 1'b0;
      ifc.i_rx_valid = 1'b0;
      ifc.i_rx_data  = '0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic pulse_next();
      nexti = 1'b1; tick(1); nexti = 1'b0; tick(1);
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (ifc.o_imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0h data %0h with none expected",
                        ifc.o_imem_addr, ifc.o_imem_wdata);
            end else begin
               e = exp_q.pop_front();
               check("imem_addr", 32'(ifc.o_imem_addr), 32'(e.addr));
               check("imem_wdata", 32'(ifc.o_imem_wdata), 32'(e.data));
            end
         end
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic [15:0] w;
      fork
         monitor();
      join_none

      // Reset state
      do_reset();
      check("rst_state", 32'(st), 32'(ST_LOAD));
      check("rst_go", 32'(go), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_max", 32'(max_addr), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_we", 32'(ifc.o_imem_we), 32'd0);

      // Basic load ending on the halt word
      add_word(16'h4126); add_word(16'h8180); add_word(16'hE000);
      run_load("load1", 5);
      check("load1_done", 32'(done), 32'd1);

      // Bytes outside LOAD are ignored (monitor flags any write)
      send_byte(8'h12, 1); send_byte(8'h34, 3);
      check("ready_extra_max", 32'(max_addr), 32'd3);

      // Step mode
      step = 1'b1; start = 1'b1; tick(1);
      check("step_idle_state", 32'(st), 32'(ST_STEP_IDLE));
      cnt = 0;
      repeat (100) begin tick(1); if (go) cnt++; end
      check("step_idle_go_low", 32'(cnt), 32'd0);
      for (int k = 0; k < 3; k++) begin
         nexti = 1'b1; tick(1); nexti = 1'b0;
         check("step_exec_go", 32'(go), 32'd1);
         tick($urandom_range(1, 4));
         if (k == 1) begin
            pulse_next(); pulse_next(); pulse_next();
         end
         check("step_exec_hold", 32'(st), 32'(ST_STEP_EXEC));
         idone = 1'b1; tick(1); idone = 1'b0;
         check("step_back_idle", 32'(st), 32'(ST_STEP_IDLE));
         tick(5);
         check("step_not_queued_go", 32'(go), 32'd0);
      end

      // Continuous mode
      start = 1'b0; tick(1);
      check("pause_from_step", 32'(st), 32'(ST_READY));
      step = 1'b0; start = 1'b1; tick(1);
      check("run_state", 32'(st), 32'(ST_RUN));
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         repeat ($urandom_range(1, 4)) begin tick(1); if (!go) cnt++; end
         idone = 1'b1; tick(1); idone = 1'b0;
         if (!go) cnt++;
      end
      check("run_go_high", 32'(cnt), 32'd0);

      // Step-mode switch waits for instruction retirement
      step = 1'b1; tick(3);
      check("run_wait_done", 32'(st), 32'(ST_RUN));
      idone = 1'b1; tick(1); idone = 1'b0;
      check("run_to_step", 32'(st), 32'(ST_STEP_IDLE));
      start = 1'b0; tick(1); step = 1'b0; start = 1'b1; tick(1);

      // Pause and resume
      start = 1'b0; tick(1);
      check("pause_state", 32'(st), 32'(ST_READY));
      check("pause_go", 32'(go), 32'd0);
      start = 1'b1; tick(1);
      check("resume_state", 32'(st), 32'(ST_RUN));
      check("resume_done", 32'(done), 32'd1);
      check("resume_max", 32'(max_addr), 32'd3);

      // Halt is terminal
      halt = 1'b1; tick(1); halt = 1'b0;
      check("halt_state", 32'(st), 32'(ST_HALTED));
      check("halt_go", 32'(go), 32'd0);
      start = 1'b0; tick(2); start = 1'b1; tick(1);
      step = 1'b1; pulse_next(); idone = 1'b1; tick(1); idone = 1'b0;
      send_byte(8'h55, 1); send_byte(8'h66, 2);
      check("halted_stays", 32'(st), 32'(ST_HALTED));
      check("halted_go", 32'(go), 32'd0);
      check("halted_max", 32'(max_addr), 32'd3);
      check("halted_done", 32'(done), 32'd1);

      // Reset in STEP_EXEC, then reload
      do_reset();
      add_word(16'h4100); add_word(16'hE000);
      run_load("load2", 3);
      step = 1'b1; start = 1'b1; tick(1);
      nexti = 1'b1; tick(1); nexti = 1'b0;
      check("pre_rst_exec", 32'(st), 32'(ST_STEP_EXEC));
      rst_n = 1'b0; #1;
      check("mid_rst_state", 32'(st), 32'(ST_LOAD));
      check("mid_rst_go", 32'(go), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_max", 32'(max_addr), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      do_reset();
      add_word(16'h4100); add_word(16'hE000);
      run_load("reload", 3);

      // Timeout with an odd byte count
      do_reset();
      bq.push_back(8'h41); bq.push_back(8'h26); bq.push_back(8'h81);
      model_load(bq);
      foreach (bq[i]) send_byte(bq[i], 0);
      bq.delete();
      tick(TMO - 2);
      check("tmo_not_early", 32'(done), 32'd0);
      wait_done(20);
      tick(2);
      check("tmo_odd_max", 32'(max_addr), 32'(exp_max));
      check("tmo_odd_err", 32'(err), 32'(exp_err));
      check("tmo_odd_pending", 32'(exp_q.size()), 32'd0);

      // Timeout with an even byte count
      do_reset();
      add_word(16'h1234);
      run_load("tmo_even", 2);

      // Randomized loads
      for (int r = 0; r < 3; r++) begin
         do_reset();
         repeat ($urandom_range(2, 10)) begin
            w = 16'($urandom);
            if (w == HALT_WORD_DEF) w = 16'h0001;
            add_word(w);
         end
         add_word(HALT_WORD_DEF);
         run_load("rand", 8);
      end

      // Address overflow
      do_reset();
      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom);
         if (w == HALT_WORD_DEF) w = 16'h0002;
         add_word(w);
      end
      run_load("ovf", 0);

      tick(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Sequencing controller between the UART byte receiver, the instruction memory and the CPU control unit.
- Load phase: assembles received byte pairs into 16-bit instruction words, writes them to instruction memory from address 1 upward, and signals load completion.
- Run phase: gates CPU execution, either free-running or one instruction per user step request, until the CPU reports halt.

Parameters:
ADDR_W, 8, instruction memory address width
START_ADDR, 1, first instruction memory address written
HALT_WORD, 16'hE000, instruction word that terminates loading
IDLE_TIMEOUT, 50000, clock cycles without a byte (after ≥1 byte) that ends loading

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_rx_valid  in  1  one-cycle strobe, new byte on i_rx_data
i_rx_data  in  8  received byte
i_start_cpu  in  1  level; high = run permitted
i_step_mode  in  1  1 = step execution, 0 = continuous
i_next_instr  in  1  step request (level/pulse; rising edge used)
i_instr_done  in  1  one-cycle strobe from CPU: current instruction retired
i_halt  in  1  CPU halted (level)
o_imem_we  out  1  instruction memory write strobe
o_imem_addr  out  ADDR_W  write address
o_imem_wdata  out  16  write data
o_instr_transmit_done  out  1  load finished (level)
o_max_addr  out  ADDR_W  last address written
o_load_err  out  1  odd byte count or address overflow at load end
o_cpu_go  out  1  CPU may fetch/execute next instruction
o_state  out  3  current state, for debug display

Behaviour:
Reset state:
- Asynchronous reset → state LOAD; all outputs 0.
- Internal addr = START_ADDR, byte toggle = 0, timeout counter = 0.

States: LOAD, READY, RUN, STEP_IDLE, STEP_EXEC, HALTED.

LOAD:
- Byte capture: on i_rx_valid with toggle=0, latch byte as high byte and set toggle=1. With toggle=1, form word {hi, byte} and set toggle=0.
- Word write: cycle after the second byte, o_imem_we=1 for exactly 1 cycle; o_imem_addr=addr, o_imem_wdata=word; o_max_addr=addr; then addr+1.
- End on HALT_WORD: if word == HALT_WORD, it is written, then → READY.
- End on timeout: counter resets on every i_rx_valid. If it reaches IDLE_TIMEOUT with ≥1 byte received → READY. If toggle=1 at that point, the half word is dropped and o_load_err=1.
- End on overflow: write to addr 2^ADDR_W−1 that is not HALT_WORD → READY, o_load_err=1.
- Extra bytes arriving outside LOAD are ignored.
- o_instr_transmit_done goes high on entry to READY and stays high until reset.

READY:
- o_cpu_go=0.
- i_start_cpu high → RUN if i_step_mode=0, STEP_IDLE if 1.

RUN:
- o_cpu_go=1 continuously.
- i_halt → HALTED (o_cpu_go low the next cycle).
- i_start_cpu low → READY (pause).
- i_step_mode changes to 1 → STEP_IDLE; takes effect only on an i_instr_done cycle, so the instruction in flight finishes.

STEP_IDLE:
- o_cpu_go=0.
- Rising edge of i_next_instr (registered compare against previous sample) → STEP_EXEC.
- i_start_cpu low → READY.
- i_halt → HALTED.

STEP_EXEC:
- o_cpu_go=1 until i_instr_done, then → STEP_IDLE.
- Further i_next_instr edges while in STEP_EXEC are ignored, not queued.
- i_halt has priority over i_instr_done in the same cycle → HALTED.

HALTED:
- o_cpu_go=0; all load outputs hold.
- Only reset exits.

Priority when several events share a cycle: reset > i_halt > i_start_cpu low > step/done events.

Reset mid-load discards partial state. The memory is not cleared; o_max_addr restarts from 0.

Decomposition:
- Shared package: state encoding constants (LOAD=0, READY=1, RUN=2, STEP_IDLE=3, STEP_EXEC=4, HALTED=5), HALT_WORD, START_ADDR. The debug display reuses these.
- One natural sub-module: rising-edge detector edge_detect_rise (registered, reset to 0), used for i_next_instr.
- Byte assembler and FSM stay in this module.

Test Plan:
- Load order: bytes 41,26,81,80,E0,00 → writes (1,16'h4126), (2,16'h8180), (3,16'hE000); done=1, o_max_addr=3, o_load_err=0.
- Timeout with odd byte: bytes 41,26,81 then silence for IDLE_TIMEOUT cycles → one write (1,16'h4126); done=1, o_max_addr=1, o_load_err=1.
- Step mode, i_step_mode=1: after start, o_cpu_go stays 0 for 100 cycles. Each i_next_instr pulse gives exactly one go window ending at i_instr_done. 3 pulses during one STEP_EXEC → still one instruction.
- Continuous mode: o_cpu_go stays high across 5 i_instr_done strobes. i_halt → o_cpu_go=0 next cycle, state=HALTED. Later i_start_cpu toggles or i_next_instr pulses → no change.
- Pause: drop i_start_cpu during RUN → READY with o_cpu_go=0. Raise it again → RUN resumes; done and o_max_addr unchanged.
- Reset in STEP_EXEC → all outputs 0, state LOAD. A new load of bytes 41,00,E0,00 writes addresses 1–2 and leaves o_max_addr=2.
